// File: rtl/sram_pkg.sv
// Shared definitions for the cs/we/oe SRAM strobe interface (target and controller).
package sram_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_WR  = 2'd1,
        OP_RD  = 2'd2,
        OP_BAD = 2'd3
    } op_t;

    // Classify the strobe pair sampled with cs; both strobes together is a protocol error.
    function automatic op_t decode_op(input logic we, input logic oe);
        unique case ({we, oe})
            2'b10:   return OP_WR;
            2'b01:   return OP_RD;
            2'b11:   return OP_BAD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sram_array.sv
// Storage behind sram_target: synchronous write, synchronous registered read.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array write port.
    // NOTE: the storage has no reset so it maps onto RAM cells and survives a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register; holds the last value read and is the only part cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_target.sv
// Responder end of the cs/we/oe SRAM interface: capture, wait states, access, one-cycle ack.
module sram_target
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_BASE   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wp,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic [7:0]        wr_cnt,
    output logic [7:0]        rd_cnt
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, next_state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wp_q;
    logic [3:0]        wcnt;

    logic load;
    logic in_resp;
    logic prot_hit;
    logic resp_err;
    logic mem_we;
    logic mem_re;

    assign prot_hit = wp_q && (int'(addr_q) >= PROT_BASE);
    assign resp_err = (op_q == OP_BAD) || ((op_q == OP_WR) && prot_hit);
    assign in_resp  = (state == ST_RESP);
    assign mem_we   = in_resp && (op_q == OP_WR) && !prot_hit;
    assign mem_re   = in_resp && (op_q == OP_RD);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a held cs is only re-sampled after HOLD sees it drop.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cs && (decode_op(we, oe) != OP_NOP)) begin
                    load       = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt == 4'd1) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!cs) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture the access and run the wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            wp_q    <= 1'b0;
            wcnt    <= '0;
        end else if (load) begin
            op_q    <= decode_op(we, oe);
            addr_q  <= addr;
            wdata_q <= wdata;
            wp_q    <= wp;
            wcnt    <= WAIT_INIT;
        end else if (state == ST_WAIT) begin
            wcnt    <= wcnt - 4'd1;
        end
    end

    // Registered response: ack and err are high only for the cycle after RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack <= 1'b0;
            err <= 1'b0;
        end else begin
            ack <= in_resp;
            err <= in_resp && resp_err;
        end
    end

    // Saturating counters of successful accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (mem_we && (wr_cnt != 8'hFF)) begin
                wr_cnt <= wr_cnt + 8'd1;
            end
            if (mem_re && (rd_cnt != 8'hFF)) begin
                rd_cnt <= rd_cnt + 8'd1;
            end
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sram_target.sv
// Scoreboard bench for sram_target: stimulus pushes expected responses, a monitor checks each ack.
module tb_sram_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs, we, oe, wp;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata, wr_cnt, rd_cnt;
    logic       ack, err;

    // Second instance with no wait states, driven like sram_controller does.
    logic       cs_z, we_z, oe_z, wp_z;
    logic [3:0] addr_z;
    logic [7:0] wdata_z;
    logic [7:0] rdata_z, wr_cnt_z, rd_cnt_z;
    logic       ack_z, err_z;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        logic [7:0] wr_cnt;
        logic [7:0] rd_cnt;
        int         cyc;
    } resp_t;

    resp_t exp_q[$];

    int exp_wr = 0;
    int exp_rd = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sram_target #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2), .PROT_BASE(12)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
        .wp(wp), .rdata(rdata), .ack(ack), .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    sram_target #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0), .PROT_BASE(12)) dut_z (
        .clk(clk), .reset(reset), .cs(cs_z), .we(we_z), .oe(oe_z), .addr(addr_z), .wdata(wdata_z),
        .wp(wp_z), .rdata(rdata_z), .ack(ack_z), .err(err_z), .wr_cnt(wr_cnt_z), .rd_cnt(rd_cnt_z)
    );

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every ack must match the oldest expected response, including its arrival cycle.
    always @(negedge clk) begin
        resp_t e;
        if (!reset && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_cycle", cyc, e.cyc);
                check("err", int'(err), int'(e.err));
                check("rdata", int'(rdata), int'(e.rdata));
                check("wr_cnt", int'(wr_cnt), int'(e.wr_cnt));
                check("rd_cnt", int'(rd_cnt), int'(e.rd_cnt));
            end
        end
    end

    // One access with a one-cycle cs pulse; returns with the target back in IDLE.
    task automatic access(input logic w, input logic o, input logic [3:0] a, input logic [7:0] d,
                          input logic p, input logic e_err, input logic [7:0] e_rdata);
        resp_t e;
        cs = 1'b1; we = w; oe = o; addr = a; wdata = d; wp = p;
        if (!e_err && w && !o && exp_wr < 255) exp_wr++;
        if (!e_err && o && !w && exp_rd < 255) exp_rd++;
        e.err    = e_err;
        e.rdata  = e_rdata;
        e.wr_cnt = 8'(exp_wr);
        e.rd_cnt = 8'(exp_rd);
        e.cyc    = cyc + 4;
        if (w || o) exp_q.push_back(e);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cs = 1'b0; we = 1'b0; oe = 1'b0; wp = 1'b0; addr = '0; wdata = '0;
        cs_z = 1'b0; we_z = 1'b0; oe_z = 1'b0; wp_z = 1'b0; addr_z = '0; wdata_z = '0;
        repeat (2) @(negedge clk);
        check("reset_rdata", int'(rdata), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_err", int'(err), 0);
        check("reset_wr_cnt", int'(wr_cnt), 0);
        check("reset_rd_cnt", int'(rd_cnt), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read with two wait states.
        access(1, 0, 4'd3, 8'hA5, 0, 0, 8'h00);
        access(0, 1, 4'd3, 8'h00, 0, 0, 8'hA5);

        // Both strobes: error, no array access, rdata and counters unchanged.
        access(1, 0, 4'd5, 8'h11, 0, 0, 8'hA5);
        access(1, 1, 4'd5, 8'hEE, 0, 1, 8'hA5);
        access(0, 1, 4'd5, 8'h00, 0, 0, 8'h11);

        // cs with neither strobe: no ack at all.
        access(0, 0, 4'd6, 8'h00, 0, 0, 8'h00);

        // Write protect: addr 13 is protected, addr 11 is not.
        access(1, 0, 4'd13, 8'h99, 0, 0, 8'h11);
        access(1, 0, 4'd13, 8'h3C, 1, 1, 8'h11);
        access(1, 0, 4'd11, 8'h3C, 1, 0, 8'h11);
        access(1, 0, 4'd12, 8'h44, 1, 1, 8'h11);
        access(0, 1, 4'd13, 8'h00, 1, 0, 8'h99);
        access(0, 1, 4'd11, 8'h00, 0, 0, 8'h3C);

        // cs held for 10 cycles: exactly one write, then a new access once cs drops.
        begin
            resp_t e;
            cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 4'd7; wdata = 8'h42; wp = 1'b0;
            exp_wr++;
            e.err = 1'b0; e.rdata = 8'h3C; e.wr_cnt = 8'(exp_wr); e.rd_cnt = 8'(exp_rd);
            e.cyc = cyc + 4;
            exp_q.push_back(e);
            repeat (10) @(negedge clk);
            cs = 1'b0; we = 1'b0;
            repeat (2) @(negedge clk);
        end
        access(0, 1, 4'd7, 8'h00, 0, 0, 8'h42);

        // Prior value for the reset test, then saturate the read counter.
        access(1, 0, 4'd2, 8'h20, 0, 0, 8'h42);
        for (int i = 0; i < 260; i++) begin
            access(0, 1, 4'd3, 8'h00, 0, 0, 8'hA5);
        end
        check("rd_cnt_saturated", int'(rd_cnt), 255);

        // Zero-wait instance: write then read addr 0xF.
        cs_z = 1'b1; we_z = 1'b1; oe_z = 1'b0; addr_z = 4'hF; wdata_z = 8'h5A;
        @(negedge clk);
        cs_z = 1'b0; we_z = 1'b0;
        check("z_wr_ack_early", int'(ack_z), 0);
        @(negedge clk);
        check("z_wr_ack", int'(ack_z), 1);
        check("z_wr_err", int'(err_z), 0);
        check("z_wr_cnt", int'(wr_cnt_z), 1);
        @(negedge clk);
        check("z_wr_ack_width", int'(ack_z), 0);
        cs_z = 1'b1; oe_z = 1'b1; addr_z = 4'hF;
        @(negedge clk);
        cs_z = 1'b0; oe_z = 1'b0;
        @(negedge clk);
        check("z_rd_ack", int'(ack_z), 1);
        check("z_rdata", int'(rdata_z), 8'h5A);
        check("z_rd_cnt", int'(rd_cnt_z), 1);
        repeat (2) @(negedge clk);

        // Reset while the write of 0x77 to addr 2 is waiting.
        cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 4'd2; wdata = 8'h77; wp = 1'b0;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_wr_cnt", int'(wr_cnt), 0);
        check("rst_rd_cnt", int'(rd_cnt), 0);
        reset = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        @(negedge clk);
        access(0, 1, 4'd2, 8'h00, 0, 0, 8'h20);
        repeat (2) @(negedge clk);

        check("pending_responses", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
